// File: rtl/circ_smpl_queue_if.sv
// Sample-stream bus between the decimated audio source, the circular queue
// and the FIR MAC that consumes the replayed bursts.
interface circ_smpl_queue_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] new_smpl;
    logic              wrt_smpl;
    logic [DATA_W-1:0] smpl_out;
    logic              sequencing;
    logic              seq_first;
    logic              seq_last;
    logic              overrun;

    modport master (
        output new_smpl, wrt_smpl,
        input  smpl_out, sequencing, seq_first, seq_last, overrun
    );

    modport slave (
        input  new_smpl, wrt_smpl,
        output smpl_out, sequencing, seq_first, seq_last, overrun
    );
endinterface

// File: rtl/circ_smpl_queue.sv
// Circular sample queue: stores decimated samples in a dual-port RAM and
// replays the newest WINDOW samples, oldest first, after each accepted write.
module circ_smpl_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int WINDOW = 1020,
    parameter int DECIM  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    circ_smpl_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] WIN_C    = CW'(WINDOW);
    localparam logic [CW-1:0] LAST_C   = CW'(WINDOW - 1);
    localparam logic [AW-1:0] WIN_A    = AW'(WINDOW);
    localparam logic [DW-1:0] DEC_LAST = DW'(DECIM - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     fill_q, fill_d;
    logic [DW-1:0]     dec_cnt_q, dec_cnt_d;
    logic              req_q, req_d;
    logic [AW-1:0]     req_base_q, req_base_d;

    state_t            state_q;
    logic [AW-1:0]     base_q;
    logic [AW-1:0]     pend_base_q;
    logic [CW-1:0]     rd_cnt_q;
    logic              pending_q;
    logic              overrun_q;
    logic [DATA_W-1:0] smpl_out_q;
    logic              sequencing_q;
    logic              seq_first_q;
    logic              seq_last_q;
    logic [AW-1:0]     rd_addr;

    always_comb begin
        accept    = bus.wrt_smpl && (dec_cnt_q == '0);
        dec_cnt_d = dec_cnt_q;
        if (bus.wrt_smpl) begin
            dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
        end
        wr_ptr_d   = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        fill_d     = (accept && (fill_q != WIN_C)) ? fill_q + 1'b1 : fill_q;
        req_d      = accept && (fill_d == WIN_C);
        // Window base is captured with the request so the raising sample is always the newest replayed.
        req_base_d = wr_ptr_d - WIN_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            dec_cnt_q  <= '0;
            req_q      <= 1'b0;
            req_base_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            dec_cnt_q  <= dec_cnt_d;
            req_q      <= req_d;
            req_base_q <= req_base_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= bus.new_smpl;
        end
    end

    assign rd_addr = base_q + AW'(rd_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            pend_base_q  <= '0;
            rd_cnt_q     <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            smpl_out_q   <= '0;
            sequencing_q <= 1'b0;
            seq_first_q  <= 1'b0;
            seq_last_q   <= 1'b0;
        end else begin
            sequencing_q <= (state_q == RUN);
            seq_first_q  <= (state_q == RUN) && (rd_cnt_q == '0);
            seq_last_q   <= (state_q == RUN) && (rd_cnt_q == LAST_C);
            if (state_q == RUN) begin
                smpl_out_q <= mem[rd_addr];
            end
            case (state_q)
                IDLE: begin
                    if (req_q) begin
                        state_q  <= RUN;
                        base_q   <= req_base_q;
                        rd_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (rd_cnt_q == LAST_C) begin
                        // A request landing on the final address either restarts directly or becomes the new pending one.
                        if (pending_q) begin
                            base_q      <= pend_base_q;
                            rd_cnt_q    <= '0;
                            pending_q   <= req_q;
                            pend_base_q <= req_base_q;
                        end else if (req_q) begin
                            base_q   <= req_base_q;
                            rd_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        if (req_q) begin
                            if (pending_q) begin
                                overrun_q <= 1'b1;
                            end else begin
                                pending_q   <= 1'b1;
                                pend_base_q <= req_base_q;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.smpl_out   = smpl_out_q;
    assign bus.sequencing = sequencing_q;
    assign bus.seq_first  = seq_first_q;
    assign bus.seq_last   = seq_last_q;
    assign bus.overrun    = overrun_q;
endmodule
